// File: rtl/imem_boot_loader_if.sv
// Word-stream handshake feeding the instruction-memory boot loader.
// The master drives s_valid/s_data; the slave (loader) returns s_ready.
interface imem_boot_loader_if #(parameter int W = 32);
  logic         s_valid;
  logic [W-1:0] s_data;
  logic         s_ready;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/imem_boot_loader.sv
// Streams a boot image (base addr, word count, data words) into the instruction
// RAM write port while holding the core. Optional checksum word: IMEM_LOADER_CKSUM_EN.
module imem_boot_loader #(
  parameter int W     = 32,
  parameter int DEPTH = 2048
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imem_boot_loader_if.slave    s,
  input  logic                 reload,
  output logic                 is_write,
  output logic [W-1:0]         im_addr,
  output logic [W-1:0]         im_inst,
  output logic                 core_hold,
  output logic                 load_done,
  output logic                 load_err,
  output logic [W-1:0]         words_written
);

  localparam logic [W-1:0] DEPTH_W = W'(DEPTH);
  localparam logic [W:0]   DEPTH_X = (W+1)'(DEPTH);

  typedef enum logic [2:0] {
    HDR_ADDR, HDR_CNT, LOAD, DONE, ERROR
`ifdef IMEM_LOADER_CKSUM_EN
    , CKSUM
`endif
  } state_t;

  state_t       state;
  logic [W-3:0] base_w;      // base word index; the byte offset is known to be zero
  logic [W-1:0] next_addr;
  logic [W-1:0] words_left;
  logic [W:0]   span;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [W-1:0] cks;
`endif

  // One bit wider than the operands so a huge count cannot wrap past the check.
  assign span = (W+1)'(base_w) + (W+1)'(s.s_data);

  always_comb begin
    s.s_ready = (state == HDR_ADDR) || (state == HDR_CNT) || (state == LOAD);
`ifdef IMEM_LOADER_CKSUM_EN
    if (state == CKSUM) s.s_ready = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HDR_ADDR;
      is_write      <= 1'b0;
      im_addr       <= '0;
      im_inst       <= '0;
      core_hold     <= 1'b1;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
      words_written <= '0;
      base_w        <= '0;
      next_addr     <= '0;
      words_left    <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      cks           <= '0;
`endif
    end else begin
      is_write  <= 1'b0;
      load_done <= 1'b0;
      case (state)
        HDR_ADDR: begin
`ifdef IMEM_LOADER_CKSUM_EN
          cks <= '0;
`endif
          if (s.s_valid) begin
            base_w <= s.s_data[W-1:2];
            if (s.s_data[1:0] != 2'b00 || (s.s_data >> 2) >= DEPTH_W) begin
              state    <= ERROR;
              load_err <= 1'b1;
            end else begin
              state <= HDR_CNT;
            end
          end
        end
        HDR_CNT: if (s.s_valid) begin
          if (s.s_data == '0) begin
            state     <= DONE;
            load_done <= 1'b1;
          end else if (span > DEPTH_X) begin
            state    <= ERROR;
            load_err <= 1'b1;
          end else begin
            state      <= LOAD;
            words_left <= s.s_data;
            next_addr  <= {base_w, 2'b00};
          end
        end
        LOAD: if (s.s_valid) begin
          is_write      <= 1'b1;
          im_addr       <= next_addr;
          im_inst       <= s.s_data;
          next_addr     <= next_addr + W'(4);
          words_left    <= words_left - W'(1);
          words_written <= words_written + W'(1);
`ifdef IMEM_LOADER_CKSUM_EN
          cks <= cks ^ s.s_data;
          if (words_left == W'(1)) state <= CKSUM;
`else
          if (words_left == W'(1)) begin
            state     <= DONE;
            load_done <= 1'b1;
          end
`endif
        end
`ifdef IMEM_LOADER_CKSUM_EN
        CKSUM: if (s.s_valid) begin
          if (s.s_data == cks) begin
            state     <= DONE;
            load_done <= 1'b1;
          end else begin
            state    <= ERROR;
            load_err <= 1'b1;
          end
        end
`endif
        DONE: begin
          // Hold drops one cycle after entry, so it never overlaps the final write.
          if (reload) begin
            state         <= HDR_ADDR;
            core_hold     <= 1'b1;
            words_written <= '0;
          end else begin
            core_hold <= 1'b0;
          end
        end
        ERROR: if (reload) begin
          state         <= HDR_ADDR;
          load_err      <= 1'b0;
          words_written <= '0;
        end
        default: state <= HDR_ADDR;
      endcase
    end
  end

endmodule
